// File: rtl/vmem_arbiter_pkg.sv
// Shared types and constants for the VRAM arbiter.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
`timescale 1ns/1ps
package vmem_arb_pkg;

  // Arbiter FSM states: one idle state plus two 2-cycle access sequences
  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_V1   = 3'd1,
    ST_V2   = 3'd2,
    ST_C1   = 3'd3,
    ST_C2   = 3'd4
  } arb_state_e;

  // Consecutive video grants allowed before a waiting CPU gets a turn
  localparam logic [1:0] VID_BURST_MAX = 2'd2;

  // True while a CPU access owns the VRAM bus
  function automatic logic is_cpu_state(input arb_state_e s);
    return (s == ST_C1) || (s == ST_C2);
  endfunction

endpackage

// File: rtl/vmem_arbiter_if.sv
// Request/strobe bundle between the video fetcher, the CPU decode and the arbiter.
// Latency: n/a (wires only).
// Backpressure: requests are held by the requester until the matching ack strobe.
`timescale 1ns/1ps
interface vmem_arbiter_if;

  logic vid_req;
  logic vid_ack;
  logic cpu_req;
  logic cpu_wr;
  logic cpu_ack;
  logic cpu_wait;
  logic n_vrd;
  logic n_vwr;
  logic vaout;
  logic vdout;

  // Requester side (video fetcher + CPU decode)
  modport master (
    output vid_req, cpu_req, cpu_wr,
    input  vid_ack, cpu_ack, cpu_wait, n_vrd, n_vwr, vaout, vdout
  );

  // Arbiter side
  modport slave (
    input  vid_req, cpu_req, cpu_wr,
    output vid_ack, cpu_ack, cpu_wait, n_vrd, n_vwr, vaout, vdout
  );

endinterface

// File: rtl/vmem_arbiter.sv
// VRAM arbiter between video fetcher and CPU; VMEM_ARB_FAIR_EN lets the CPU in after a video burst.
// Latency: every access takes two clk14 cycles; grant is decided in IDLE/V2/C2 so accesses chain back-to-back.
// Backpressure: requests held until ack; cpu_wait stretches the CPU while its request is not being served.
`timescale 1ns/1ps
module vmem_arbiter
  import vmem_arb_pkg::*;
(
  input  logic           clk14,
  input  logic           rst_n,
  vmem_arbiter_if.slave  bus
);

  arb_state_e state_q, state_d;
  logic       wr_q, wr_d;           // direction latched at CPU grant
  logic       cpu_done_q, cpu_done_d; // blocks re-granting a still-held cpu_req
  logic       vid_ack_q, vid_ack_d;
  logic       cpu_ack_q, cpu_ack_d;
  logic       n_vrd_q, n_vrd_d;
  logic       n_vwr_q, n_vwr_d;
  logic       vaout_q, vaout_d;
  logic       vdout_q, vdout_d;

  logic       decide;
  logic       cpu_elig;
  logic       grant_vid;
  logic       grant_cpu;

`ifdef VMEM_ARB_FAIR_EN
  logic [1:0] vid_cnt_q, vid_cnt_d;
`endif

  // Grant decision: only at the end of IDLE or of the second cycle of an access
  always_comb begin
    decide    = (state_q == ST_IDLE) || (state_q == ST_V2) || (state_q == ST_C2);
    // In C2 the CPU is being served right now, so a held request is not a new one
    cpu_elig  = bus.cpu_req && !cpu_done_q && (state_q != ST_C2);
`ifdef VMEM_ARB_FAIR_EN
    grant_vid = decide && bus.vid_req && !(cpu_elig && (vid_cnt_q == VID_BURST_MAX));
`else
    grant_vid = decide && bus.vid_req;
`endif
    grant_cpu = decide && cpu_elig && !grant_vid;
  end

  // Next state, latched direction and duplicate-access guard
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_V1:   state_d = ST_V2;
      ST_C1:   state_d = ST_C2;
      default: begin
        if (grant_vid)      state_d = ST_V1;
        else if (grant_cpu) state_d = ST_C1;
        else                state_d = ST_IDLE;
      end
    endcase

    wr_d = grant_cpu ? bus.cpu_wr : wr_q;

    // A low cpu_req always re-arms; otherwise set when the access completes
    if (!bus.cpu_req)          cpu_done_d = 1'b0;
    else if (state_q == ST_C2) cpu_done_d = 1'b1;
    else                       cpu_done_d = cpu_done_q;
  end

`ifdef VMEM_ARB_FAIR_EN
  // Saturating count of consecutive video grants; any CPU grant restarts it
  always_comb begin
    vid_cnt_d = vid_cnt_q;
    if (grant_cpu)
      vid_cnt_d = 2'd0;
    else if (grant_vid && (vid_cnt_q != VID_BURST_MAX))
      vid_cnt_d = vid_cnt_q + 2'd1;
  end
`endif

  // Registered strobes decoded from the state being entered
  always_comb begin
    vid_ack_d = (state_d == ST_V2);
    cpu_ack_d = (state_d == ST_C2);
    n_vrd_d   = 1'b1;
    n_vwr_d   = 1'b1;
    vaout_d   = 1'b1;
    vdout_d   = 1'b1;
    case (state_d)
      ST_V1, ST_V2: n_vrd_d = 1'b0;
      ST_C1, ST_C2: begin
        vaout_d = 1'b0;
        if (wr_d) begin
          vdout_d = 1'b0;
          n_vwr_d = (state_d != ST_C1);  // write pulse only in the first cycle
        end else begin
          n_vrd_d = 1'b0;
        end
      end
      default: ;
    endcase
  end

  // State and output registers; reset abandons any access without an ack
  always_ff @(posedge clk14 or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      wr_q       <= 1'b0;
      cpu_done_q <= 1'b0;
      vid_ack_q  <= 1'b0;
      cpu_ack_q  <= 1'b0;
      n_vrd_q    <= 1'b1;
      n_vwr_q    <= 1'b1;
      vaout_q    <= 1'b1;
      vdout_q    <= 1'b1;
    end else begin
      state_q    <= state_d;
      wr_q       <= wr_d;
      cpu_done_q <= cpu_done_d;
      vid_ack_q  <= vid_ack_d;
      cpu_ack_q  <= cpu_ack_d;
      n_vrd_q    <= n_vrd_d;
      n_vwr_q    <= n_vwr_d;
      vaout_q    <= vaout_d;
      vdout_q    <= vdout_d;
    end
  end

`ifdef VMEM_ARB_FAIR_EN
  // Video burst counter register
  always_ff @(posedge clk14 or negedge rst_n) begin
    if (!rst_n) vid_cnt_q <= 2'd0;
    else        vid_cnt_q <= vid_cnt_d;
  end
`endif

  assign bus.vid_ack  = vid_ack_q;
  assign bus.cpu_ack  = cpu_ack_q;
  assign bus.n_vrd    = n_vrd_q;
  assign bus.n_vwr    = n_vwr_q;
  assign bus.vaout    = vaout_q;
  assign bus.vdout    = vdout_q;
  // Combinational so the CPU is stretched in the same cycle it asks
  assign bus.cpu_wait = bus.cpu_req && !cpu_done_q && !is_cpu_state(state_q);

endmodule

// File: tb/tb_vmem_arbiter.sv
// Directed bench for vmem_arbiter: per-cycle vector table plus async-reset and held-write sequences.
// Latency: inputs driven on negedge, outputs sampled 1ns after the following posedge.
// Backpressure: n/a.
`timescale 1ns/1ps
module tb_vmem_arbiter;

  logic clk14 = 1'b0;
  logic rst_n = 1'b0;
  vmem_arbiter_if bus();

  vmem_arbiter dut (.clk14(clk14), .rst_n(rst_n), .bus(bus));

  always #35 clk14 = ~clk14;

  // Output vector order: {vid_ack, cpu_ack, n_vrd, n_vwr, vaout, vdout}
  localparam logic [5:0] E_IDLE = 6'b001111;
  localparam logic [5:0] E_V1   = 6'b000111;
  localparam logic [5:0] E_V2   = 6'b100111;
  localparam logic [5:0] E_CR1  = 6'b000101;
  localparam logic [5:0] E_CR2  = 6'b010101;
  localparam logic [5:0] E_CW1  = 6'b001000;
  localparam logic [5:0] E_CW2  = 6'b011100;

  typedef struct {
    string      name;
    logic       rst;
    logic       vreq;
    logic       creq;
    logic       cwr;
    logic [5:0] eo;
    logic       ew;
  } vec_t;

  vec_t tbl[$];
  int   checks   = 0;
  int   failures = 0;

  task automatic add(input string n, input logic r, input logic v, input logic c,
                     input logic w, input logic [5:0] eo, input logic ew);
    vec_t t;
    t.name = n; t.rst = r; t.vreq = v; t.creq = c; t.cwr = w; t.eo = eo; t.ew = ew;
    tbl.push_back(t);
  endtask

  task automatic chk(input string nm, input int got, input int exp);
    checks++;
    if (got != exp) begin
      failures++;
      $display("FAIL %s got=%0h expected=%0h", nm, got, exp);
    end
  endtask

  function automatic logic [5:0] outs();
    return {bus.vid_ack, bus.cpu_ack, bus.n_vrd, bus.n_vwr, bus.vaout, bus.vdout};
  endfunction

  initial begin
    #200000;
    $display("FAIL timeout checks=%0d", checks);
    $fatal(1, "timeout");
  end

  initial begin
    bus.vid_req = 1'b0;
    bus.cpu_req = 1'b0;
    bus.cpu_wr  = 1'b0;

    //   name            rst v  c  wr expected  wait
    add("rst_hold",      0, 0, 0, 0, E_IDLE, 0);
    add("idle",          1, 0, 0, 0, E_IDLE, 0);
    add("rd_c1",         1, 0, 1, 0, E_CR1,  0);
    add("rd_c2",         1, 0, 1, 0, E_CR2,  0);
    add("rd_held",       1, 0, 1, 0, E_IDLE, 0);
    add("rd_rel",        1, 0, 0, 0, E_IDLE, 0);
    add("wr_c1",         1, 0, 1, 1, E_CW1,  0);
    add("wr_c2",         1, 0, 1, 0, E_CW2,  0);
    add("wr_held",       1, 0, 1, 1, E_IDLE, 0);
    add("wr_held2",      1, 0, 1, 1, E_IDLE, 0);
    add("wr_rel",        1, 0, 0, 0, E_IDLE, 0);
    add("sim_v1",        1, 1, 1, 0, E_V1,   1);
    add("sim_v2",        1, 1, 1, 0, E_V2,   1);
    add("sim_c1",        1, 0, 1, 0, E_CR1,  0);
    add("sim_c2",        1, 0, 1, 0, E_CR2,  0);
    add("sim_end",       1, 0, 0, 0, E_IDLE, 0);
    add("gap",           1, 0, 0, 0, E_IDLE, 0);
    add("drop_c1",       1, 0, 1, 0, E_CR1,  0);
    add("drop_c2",       1, 0, 0, 0, E_CR2,  0);
    add("drop_idle",     1, 0, 0, 0, E_IDLE, 0);
    add("drop_regrant",  1, 0, 1, 1, E_CW1,  0);
    add("drop_rg_c2",    1, 0, 0, 1, E_CW2,  0);
    add("drop_end",      1, 0, 0, 0, E_IDLE, 0);
    add("rv_v1",         1, 1, 0, 0, E_V1,   0);
    add("rv_rst",        0, 1, 0, 0, E_IDLE, 0);
    add("rv_after",      1, 0, 0, 0, E_IDLE, 0);
    add("rel_hold",      0, 1, 0, 0, E_IDLE, 0);
    add("rel_first",     1, 1, 0, 0, E_V1,   0);
    add("rel_v2",        1, 1, 0, 0, E_V2,   0);
    add("rel_end",       1, 0, 0, 0, E_IDLE, 0);
    add("pre_c1",        1, 0, 1, 0, E_CR1,  0);
    add("pre_c2",        1, 0, 1, 0, E_CR2,  0);
    add("pre_end",       1, 0, 0, 0, E_IDLE, 0);
    add("ct_v1a",        1, 1, 1, 0, E_V1,   1);
    add("ct_v2a",        1, 1, 1, 0, E_V2,   1);
    add("ct_v1b",        1, 1, 1, 0, E_V1,   1);
    add("ct_v2b",        1, 1, 1, 0, E_V2,   1);
`ifdef VMEM_ARB_FAIR_EN
    add("ct_c1a",        1, 1, 1, 0, E_CR1,  0);
    add("ct_c2a",        1, 1, 1, 0, E_CR2,  0);
    add("ct_v1c",        1, 1, 0, 0, E_V1,   0);
    add("ct_v2c",        1, 1, 1, 0, E_V2,   1);
    add("ct_v1d",        1, 1, 1, 0, E_V1,   1);
    add("ct_v2d",        1, 1, 1, 0, E_V2,   1);
    add("ct_c1b",        1, 1, 1, 0, E_CR1,  0);
    add("ct_c2b",        1, 1, 1, 0, E_CR2,  0);
`else
    add("ct_v1c",        1, 1, 1, 0, E_V1,   1);
    add("ct_v2c",        1, 1, 1, 0, E_V2,   1);
    add("ct_v1d",        1, 1, 0, 0, E_V1,   0);
    add("ct_v2d",        1, 1, 1, 0, E_V2,   1);
    add("ct_v1e",        1, 1, 1, 0, E_V1,   1);
    add("ct_v2e",        1, 1, 1, 0, E_V2,   1);
`endif
    add("ct_end",        1, 0, 0, 0, E_IDLE, 0);

    foreach (tbl[i]) begin
      @(negedge clk14);
      rst_n       = tbl[i].rst;
      bus.vid_req = tbl[i].vreq;
      bus.cpu_req = tbl[i].creq;
      bus.cpu_wr  = tbl[i].cwr;
      @(posedge clk14);
      #1;
      chk({tbl[i].name, "_outs"}, int'(outs()), int'(tbl[i].eo));
      chk({tbl[i].name, "_wait"}, int'(bus.cpu_wait), int'(tbl[i].ew));
    end

    // Reset asserted in the middle of V1 must act without waiting for a clock edge
    @(negedge clk14);
    bus.vid_req = 1'b1;
    @(posedge clk14);
    #1;
    chk("seqa_in_v1_nvrd", int'(bus.n_vrd), 0);
    #10;
    rst_n = 1'b0;
    #1;
    chk("seqa_async_outs", int'(outs()), int'(E_IDLE));
    @(negedge clk14);
    bus.vid_req = 1'b0;
    @(negedge clk14);
    rst_n = 1'b1;
    begin
      int vacks = 0;
      for (int c = 0; c < 4; c++) begin
        @(posedge clk14);
        #1;
        if (bus.vid_ack) vacks++;
      end
      chk("seqa_no_vid_ack", vacks, 0);
    end

    // Held write request: one write pulse, one ack on the second cycle, no repeat
    @(negedge clk14);
    bus.cpu_req = 1'b1;
    bus.cpu_wr  = 1'b1;
    begin
      int nwr = 0;
      int acks = 0;
      int first_ack = 0;
      int vdlow = 0;
      for (int c = 1; c <= 6; c++) begin
        @(posedge clk14);
        #1;
        if (!bus.n_vwr) nwr++;
        if (!bus.vdout) vdlow++;
        if (bus.cpu_ack) begin
          acks++;
          if (first_ack == 0) first_ack = c;
        end
      end
      chk("seqb_nvwr_cycles", nwr, 1);
      chk("seqb_vdout_cycles", vdlow, 2);
      chk("seqb_ack_count", acks, 1);
      chk("seqb_ack_latency", first_ack, 2);
    end
    @(negedge clk14);
    bus.cpu_req = 1'b0;
    bus.cpu_wr  = 1'b0;
    @(posedge clk14);
    #1;
    chk("seqb_final_idle", int'(outs()), int'(E_IDLE));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
